// File: rtl/tlb_nport.sv
`default_nettype none
// ============================================================================
// Module      : tlb_nport
// Description : Fully associative joint TLB with NSEARCH registered lookup
//               ports, a TLBP/TLBR/TLBWI/TLBWR management port and CP0 Random.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_nport #(
    parameter int TLBNUM  = 16,
    parameter int NSEARCH = 2,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            asid,
    input  logic [NSEARCH-1:0]    s_valid,
    input  logic [NSEARCH*19-1:0] s_vpn2,
    input  logic [NSEARCH-1:0]    s_odd,
    output logic [NSEARCH-1:0]    r_valid,
    output logic [NSEARCH-1:0]    r_found,
    output logic [NSEARCH-1:0]    r_multihit,
    output logic [NSEARCH*IW-1:0] r_index,
    output logic [NSEARCH*20-1:0] r_pfn,
    output logic [NSEARCH*3-1:0]  r_c,
    output logic [NSEARCH-1:0]    r_d,
    output logic [NSEARCH-1:0]    r_v,
    input  logic                  op_valid,
    input  logic [1:0]            op,
    input  logic [IW-1:0]         op_index,
    input  logic [77:0]           w_entry,
    input  logic [IW-1:0]         wired,
    input  logic                  wired_we,
    output logic                  op_done,
    output logic                  p_found,
    output logic [IW-1:0]         p_index,
    output logic [77:0]           rd_entry,
    output logic [IW-1:0]         random
);

    localparam logic [1:0]    c_OP_TLBP  = 2'b00;
    localparam logic [1:0]    c_OP_TLBR  = 2'b01;
    localparam logic [1:0]    c_OP_TLBWI = 2'b10;
    localparam logic [1:0]    c_OP_TLBWR = 2'b11;
    localparam logic [IW-1:0] c_RAND_TOP = IW'(TLBNUM - 1);

    typedef struct packed {
        logic          found;
        logic          multi;
        logic [IW-1:0] idx;
    } lkp_t;

    logic [77:0]       r_entry [TLBNUM];
    logic [TLBNUM-1:0] r_vld;
    logic [IW-1:0]     r_random;

    // Ascending scan: the first hit fixes the index, any later hit flags multi-hit.
    function automatic lkp_t f_lookup(input logic [18:0] vpn2, input logic [7:0] id);
        lkp_t res;
        res = '0;
        for (int e = 0; e < TLBNUM; e++) begin
            if (r_vld[e] && (r_entry[e][77:59] == vpn2) &&
                (r_entry[e][50] || (r_entry[e][58:51] == id))) begin
                if (res.found) begin
                    res.multi = 1'b1;
                end else begin
                    res.found = 1'b1;
                    res.idx   = IW'(e);
                end
            end
        end
        return res;
    endfunction

    lkp_t        w_lkp  [NSEARCH];
    logic [24:0] w_page [NSEARCH];

    // Both page halves share the layout {pfn[24:5], c[4:2], d[1], v[0]}.
    for (genvar k = 0; k < NSEARCH; k++) begin : g_port
        assign w_lkp[k]  = f_lookup(s_vpn2[19*k +: 19], asid);
        assign w_page[k] = !w_lkp[k].found ? 25'd0 :
                           s_odd[k] ? r_entry[w_lkp[k].idx][24:0] :
                                      r_entry[w_lkp[k].idx][49:25];
    end

    lkp_t          w_plkp;
    logic          w_wr_en;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_random_nxt;

    assign w_plkp   = f_lookup(w_entry[77:59], w_entry[58:51]);
    assign w_wr_en  = op_valid && op[1];
    assign w_wr_idx = (op == c_OP_TLBWR) ? r_random : op_index;
    assign random   = r_random;

    always_comb begin
        w_random_nxt = r_random - IW'(1);
        if (wired_we || (r_random == wired) || (wired == c_RAND_TOP)) begin
            w_random_nxt = c_RAND_TOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < TLBNUM; e++) begin
                r_entry[e] <= '0;
            end
            r_vld      <= '0;
            r_random   <= c_RAND_TOP;
            r_valid    <= '0;
            r_found    <= '0;
            r_multihit <= '0;
            r_index    <= '0;
            r_pfn      <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_v        <= '0;
            op_done    <= 1'b0;
            p_found    <= 1'b0;
            p_index    <= '0;
            rd_entry   <= '0;
        end else begin
            for (int k = 0; k < NSEARCH; k++) begin
                r_valid[k] <= s_valid[k];
                if (s_valid[k]) begin
                    r_found[k]            <= w_lkp[k].found;
                    r_multihit[k]         <= w_lkp[k].multi;
                    r_index[k*IW +: IW]   <= w_lkp[k].idx;
                    r_pfn[k*20 +: 20]     <= w_page[k][24:5];
                    r_c[k*3 +: 3]         <= w_page[k][4:2];
                    r_d[k]                <= w_page[k][1];
                    r_v[k]                <= w_page[k][0];
                end
            end

            op_done <= op_valid;
            if (op_valid && (op == c_OP_TLBP)) begin
                p_found <= w_plkp.found;
                p_index <= w_plkp.idx;
            end
            if (op_valid && (op == c_OP_TLBR)) begin
                rd_entry <= r_vld[op_index] ? r_entry[op_index] : 78'd0;
            end
            if (w_wr_en) begin
                r_entry[w_wr_idx] <= w_entry;
                r_vld[w_wr_idx]   <= 1'b1;
            end

            r_random <= w_random_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlb_nport.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_nport
// Description : Self-checking bench for tlb_nport (directed table + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_nport;

    logic        clk;
    logic        rst;
    logic [7:0]  asid;
    logic [1:0]  s_valid;
    logic [37:0] s_vpn2;
    logic [1:0]  s_odd;
    logic [1:0]  r_valid, r_found, r_multihit, r_d, r_v;
    logic [7:0]  r_index;
    logic [39:0] r_pfn;
    logic [5:0]  r_c;
    logic        op_valid;
    logic [1:0]  op;
    logic [3:0]  op_index;
    logic [77:0] w_entry;
    logic [3:0]  wired;
    logic        wired_we;
    logic        op_done, p_found;
    logic [3:0]  p_index;
    logic [77:0] rd_entry;
    logic [3:0]  random;

    tlb_nport #(.TLBNUM(16), .NSEARCH(2)) dut (
        .clk(clk), .rst(rst), .asid(asid),
        .s_valid(s_valid), .s_vpn2(s_vpn2), .s_odd(s_odd),
        .r_valid(r_valid), .r_found(r_found), .r_multihit(r_multihit),
        .r_index(r_index), .r_pfn(r_pfn), .r_c(r_c), .r_d(r_d), .r_v(r_v),
        .op_valid(op_valid), .op(op), .op_index(op_index), .w_entry(w_entry),
        .wired(wired), .wired_we(wired_we),
        .op_done(op_done), .p_found(p_found), .p_index(p_index),
        .rd_entry(rd_entry), .random(random)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: entry images, valid flags and the Random register.
    logic [77:0] m_entry [16];
    logic        m_valid [16];
    logic [3:0]  m_random;

    // Expected registered outputs (held across idle cycles).
    logic [30:0] e_srch [2];
    logic [1:0]  e_rv;
    logic        e_done;
    logic [4:0]  e_p;
    logic [77:0] e_rd;

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] a, input logic g,
                                       input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                                       input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        return {vpn2, a, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    // Result packed as {found, index[3:0], multi, pfn[19:0], c[2:0], d, v}.
    function automatic logic [30:0] m_lookup(input logic [18:0] vpn2, input logic [7:0] a, input logic odd);
        int          hits[$];
        logic [77:0] e;
        logic [24:0] pg;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_entry[i][77:59] == vpn2 && (m_entry[i][50] || m_entry[i][58:51] == a))
                hits.push_back(i);
        end
        if (hits.size() == 0) return 31'd0;
        e  = m_entry[hits[0]];
        pg = odd ? e[24:0] : e[49:25];
        return {1'b1, 4'(hits[0]), hits.size() > 1, pg[24:5], pg[4:2], pg[1], pg[0]};
    endfunction

    function automatic logic [30:0] dut_srch(input int k);
        return {r_found[k], r_index[k*4 +: 4], r_multihit[k], r_pfn[k*20 +: 20],
                r_c[k*3 +: 3], r_d[k], r_v[k]};
    endfunction

    // One clock: predict from pre-edge state, advance the model, compare everything.
    task automatic step();
        logic [30:0] t;
        logic        wr;
        logic [3:0]  widx;
        logic [77:0] wdat;
        logic [3:0]  nr;
        for (int k = 0; k < 2; k++)
            if (s_valid[k]) e_srch[k] = m_lookup(s_vpn2[19*k +: 19], asid, s_odd[k]);
        e_rv   = s_valid;
        e_done = op_valid;
        if (op_valid && op == 2'b00) begin
            t   = m_lookup(w_entry[77:59], w_entry[58:51], 1'b0);
            e_p = {t[30], t[29:26]};
        end
        if (op_valid && op == 2'b01) e_rd = m_valid[op_index] ? m_entry[op_index] : 78'd0;
        wr   = op_valid && (op == 2'b10 || op == 2'b11);
        widx = (op == 2'b11) ? m_random : op_index;
        wdat = w_entry;
        if (wired_we || m_random == wired || wired == 4'd15) nr = 4'd15;
        else nr = m_random - 4'd1;
        @(posedge clk);
        #1;
        if (wr) begin
            m_entry[widx] = wdat;
            m_valid[widx] = 1'b1;
        end
        m_random = nr;
        for (int k = 0; k < 2; k++) chk("search", 78'(dut_srch(k)), 78'(e_srch[k]));
        chk("r_valid", 78'(r_valid), 78'(e_rv));
        chk("op_done", 78'(op_done), 78'(e_done));
        chk("tlbp", 78'({p_found, p_index}), 78'(e_p));
        chk("tlbr", rd_entry, e_rd);
        chk("random", 78'(random), 78'(m_random));
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear, holds through one edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", 78'({r_valid, r_found, r_multihit, r_index, r_pfn, r_c, r_d, r_v,
                                 op_done, p_found, p_index}), 78'd0);
        chk("rst_rd_entry", rd_entry, 78'd0);
        chk("rst_random", 78'(random), 78'd15);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        op_valid = 1'b0;
        s_valid  = 2'b00;
        wired_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_entry[i] = 78'd0;
            m_valid[i] = 1'b0;
        end
        m_random  = 4'd15;
        e_srch[0] = 31'd0;
        e_srch[1] = 31'd0;
        e_rv = 2'b00; e_done = 1'b0; e_p = 5'd0; e_rd = 78'd0;
    endtask

    typedef struct {
        logic        opv;
        logic [1:0]  op;
        logic [3:0]  idx;
        logic [77:0] we;
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic        found;
        logic [3:0]  index;
        logic        multi;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        pf;
        logic [3:0]  pi;
        logic [77:0] rd;
    } vec_t;

    vec_t        tbl [12];
    logic [77:0] ea, eag, eb, eb2, ep1, ep2, ec;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; asid = 8'd0; s_valid = 2'b00; s_vpn2 = 38'd0; s_odd = 2'b00;
        op_valid = 1'b0; op = 2'b00; op_index = 4'd0; w_entry = 78'd0;
        wired = 4'd4; wired_we = 1'b0;

        ea  = mk(19'h12345, 8'h05, 1'b0, 20'h00AAA, 3'd0, 1'b0, 1'b1, 20'h00BBB, 3'd0, 1'b1, 1'b0);
        eag = mk(19'h12345, 8'h05, 1'b1, 20'h00AAA, 3'd0, 1'b0, 1'b1, 20'h00BBB, 3'd0, 1'b1, 1'b0);
        eb  = mk(19'h0ABCD, 8'h00, 1'b1, 20'h11111, 3'd3, 1'b1, 1'b1, 20'h22222, 3'd5, 1'b0, 1'b1);
        eb2 = mk(19'h0ABCD, 8'h00, 1'b1, 20'h33333, 3'd1, 1'b0, 1'b1, 20'h44444, 3'd0, 1'b0, 1'b0);
        ep1 = mk(19'h0ABCD, 8'h77, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
        ep2 = mk(19'h55555, 8'h77, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
        ec  = mk(19'h07777, 8'h01, 1'b1, 20'h55555, 3'd2, 1'b1, 1'b1, 20'h66666, 3'd2, 1'b1, 1'b1);

        //          opv   op     idx    we     vpn2        odd   asid   fnd   index  mul   pfn          c     d     v     pf    pi     rd
        tbl[0]  = '{1'b0, 2'd0, 4'd0, 78'd0, 19'h00000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[1]  = '{1'b1, 2'd2, 4'd3, ea,    19'h12345, 1'b1, 8'h05, 1'b0, 4'd0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[2]  = '{1'b0, 2'd0, 4'd0, 78'd0, 19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 1'b0, 20'h00BBB, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[3]  = '{1'b0, 2'd0, 4'd0, 78'd0, 19'h12345, 1'b1, 8'h06, 1'b0, 4'd0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[4]  = '{1'b1, 2'd2, 4'd3, eag,   19'h12345, 1'b1, 8'h06, 1'b0, 4'd0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[5]  = '{1'b0, 2'd0, 4'd0, 78'd0, 19'h12345, 1'b1, 8'h06, 1'b1, 4'd3, 1'b0, 20'h00BBB, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[6]  = '{1'b1, 2'd1, 4'd3, 78'd0, 19'h12345, 1'b0, 8'h06, 1'b1, 4'd3, 1'b0, 20'h00AAA, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, eag};
        tbl[7]  = '{1'b1, 2'd2, 4'd2, eb,    19'h0ABCD, 1'b0, 8'h77, 1'b0, 4'd0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 78'd0};
        tbl[8]  = '{1'b1, 2'd2, 4'd9, eb2,   19'h0ABCD, 1'b0, 8'h77, 1'b1, 4'd2, 1'b0, 20'h11111, 3'd3, 1'b1, 1'b1, 1'b0, 4'd0, 78'd0};
        tbl[9]  = '{1'b1, 2'd0, 4'd0, ep1,   19'h0ABCD, 1'b0, 8'h77, 1'b1, 4'd2, 1'b1, 20'h11111, 3'd3, 1'b1, 1'b1, 1'b1, 4'd2, 78'd0};
        tbl[10] = '{1'b1, 2'd0, 4'd0, ep2,   19'h0ABCD, 1'b1, 8'h77, 1'b1, 4'd2, 1'b1, 20'h22222, 3'd5, 1'b0, 1'b1, 1'b0, 4'd0, 78'd0};
        tbl[11] = '{1'b1, 2'd1, 4'd5, 78'd0, 19'h55555, 1'b0, 8'h77, 1'b0, 4'd0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 78'd0};

        do_reset();

        // Random counter with wired=4: 15 down to 4, then reload.
        for (int n = 1; n <= 30; n++) begin
            step();
            chk("random_seq", 78'(random), 78'(15 - (n % 12)));
        end
        begin
            int guard;
            guard = 0;
            while (m_random != 4'd9 && guard < 20) begin
                step();
                guard++;
            end
            chk("random_reach9", 78'(random), 78'd9);
            wired_we = 1'b1;
            step();
            wired_we = 1'b0;
            chk("random_wired_we", 78'(random), 78'd15);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            op_valid = tbl[i].opv;
            op       = tbl[i].op;
            op_index = tbl[i].idx;
            w_entry  = tbl[i].we;
            s_valid  = 2'b11;
            s_vpn2   = {tbl[i].vpn2, tbl[i].vpn2};
            s_odd    = {2{tbl[i].odd}};
            asid     = tbl[i].asid;
            step();
            for (int k = 0; k < 2; k++)
                chk("tbl_search", 78'(dut_srch(k)),
                    78'({tbl[i].found, tbl[i].index, tbl[i].multi, tbl[i].pfn, tbl[i].c, tbl[i].d, tbl[i].v}));
            if (tbl[i].opv && tbl[i].op == 2'd0) chk("tbl_tlbp", 78'({p_found, p_index}), 78'({tbl[i].pf, tbl[i].pi}));
            if (tbl[i].opv && tbl[i].op == 2'd1) chk("tbl_tlbr", rd_entry, tbl[i].rd);
        end

        // Reset arriving while a TLBWR is pending must drop the write.
        op_valid = 1'b0;
        s_valid  = 2'b11;
        s_vpn2   = {19'h12345, 19'h12345};
        s_odd    = 2'b11;
        asid     = 8'h05;
        step();
        chk("pre_rst_hit", 78'(r_found), 78'(2'b11));
        op_valid = 1'b1;
        op       = 2'b11;
        w_entry  = ec;
        s_vpn2   = {19'h07777, 19'h07777};
        do_reset();
        s_valid  = 2'b11;
        op_valid = 1'b1;
        op       = 2'b01;
        op_index = 4'd15;
        step();
        chk("rst_drop_search", 78'(r_found), 78'd0);
        chk("rst_drop_rd", rd_entry, 78'd0);

        // Randomised traffic against the reference model.
        wired = 4'd2;
        for (int n = 0; n < 500; n++) begin
            logic [77:0] t;
            s_valid = 2'($urandom);
            for (int k = 0; k < 2; k++) s_vpn2[19*k +: 19] = 19'(32'h100 + $urandom_range(0, 3));
            s_odd    = 2'($urandom);
            asid     = 8'($urandom_range(0, 3));
            op_valid = 1'($urandom);
            op       = 2'($urandom);
            op_index = 4'($urandom);
            t = {14'($urandom), $urandom, $urandom};
            t[77:59] = 19'(32'h100 + $urandom_range(0, 3));
            t[58:51] = 8'($urandom_range(0, 3));
            w_entry  = t;
            wired_we = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
